pw_candidate_checker: RTL and testbench

//  Downstream consumer of the cascaded 4-bit digit counters in the Day 4 password datapath.

---
 rtl/pw_candidate_checker_if.sv | 28 ++
 rtl/pw_candidate_checker.sv | 138 +++++++++++++
 tb/tb_pw_candidate_checker.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/pw_candidate_checker_if.sv
// Candidate handshake bundle for pw_candidate_checker.
//   in_valid  : candidate present on in_digits
//   in_ready  : checker accepts a candidate this cycle
//   in_digits : DIGITS BCD nibbles, [3:0] = most significant digit
//   in_last   : qualifies the final candidate of the range
// master = candidate producer, slave = checker.
interface pw_candidate_checker_if #(
  parameter int unsigned DIGITS = 6
);
  logic                  in_valid;
  logic                  in_ready;
  logic [4*DIGITS-1:0]   in_digits;
  logic                  in_last;

  modport master (
    output in_valid,
    output in_digits,
    output in_last,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  in_digits,
    input  in_last,
    output in_ready
  );
endinterface

// File: rtl/pw_candidate_checker.sv
// pw_candidate_checker
// Checks six-digit (DIGITS) BCD password candidates with a 2-stage pipeline:
// a candidate matches when its digits never decrease left to right, at least
// one adjacent pair is equal, and every nibble is a valid BCD digit. Matches
// are counted (saturating) until the candidate flagged in_last has passed
// through the pipeline, after which done is held.
// Ports:
//   clk          clock, rising edge
//   rst          synchronous reset, active-low
//   start        pulse: clear count/flags/pipeline and enter RUN
//   in_if        candidate handshake (slave side)
//   match_pulse  1-cycle pulse per matching candidate
//   match_count  number of matching candidates (saturating)
//   bad_digit    sticky: a nibble > 9 was seen
//   done         range fully checked, count final
module pw_candidate_checker #(
  parameter int unsigned DIGITS  = 6,
  parameter int unsigned COUNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  pw_candidate_checker_if.slave in_if,
  output logic                 match_pulse,
  output logic [COUNT_W-1:0]   match_count,
  output logic                 bad_digit,
  output logic                 done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_e;

  state_e state_q, state_d;

  logic               accept;

  // Stage 1 registers
  logic               s1_v_q;
  logic [DIGITS-2:0]  le_d, le_q;
  logic [DIGITS-2:0]  eq_d, eq_q;
  logic               any_bad_d, any_bad_q;

  // Stage 2 / output registers
  logic               pulse_q;
  logic [COUNT_W-1:0] count_q;
  logic               bad_digit_q;

  logic               match;

  // start wins over a simultaneous accept
  assign accept = in_if.in_valid & (state_q == S_RUN) & ~start;

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_d = state_q;
    if (start) begin
      state_d = S_RUN;
    end else begin
      unique case (state_q)
        S_IDLE:  state_d = S_IDLE;
        S_RUN:   if (accept && in_if.in_last) state_d = S_DRAIN;
        // No accepts happen in DRAIN, so once stage 1 is empty this edge
        // moves its last entry out of stage 2 and both stages are empty.
        S_DRAIN: if (!s1_v_q) state_d = S_DONE;
        S_DONE:  state_d = S_DONE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    in_if.in_ready = (state_q == S_RUN);
    done           = (state_q == S_DONE);
  end

  // ---------------- Stage 1 compare logic ----------------
  always_comb begin
    le_d      = '0;
    eq_d      = '0;
    any_bad_d = 1'b0;
    for (int unsigned i = 0; i < DIGITS - 1; i++) begin
      le_d[i] = in_if.in_digits[4*i +: 4] <= in_if.in_digits[4*(i+1) +: 4];
      eq_d[i] = in_if.in_digits[4*i +: 4] == in_if.in_digits[4*(i+1) +: 4];
    end
    for (int unsigned i = 0; i < DIGITS; i++) begin
      any_bad_d = any_bad_d | (in_if.in_digits[4*i +: 4] > 4'd9);
    end
  end

  // Data registers only load on accept; their validity is carried by s1_v_q.
  always_ff @(posedge clk) begin
    if (accept) begin
      le_q      <= le_d;
      eq_q      <= eq_d;
      any_bad_q <= any_bad_d;
    end
  end

  assign match = (&le_q) & (|eq_q) & ~any_bad_q;

  // ---------------- Pipeline valids, count, flags ----------------
  always_ff @(posedge clk) begin
    if (!rst || start) begin
      s1_v_q      <= 1'b0;
      pulse_q     <= 1'b0;
      count_q     <= '0;
      bad_digit_q <= 1'b0;
    end else begin
      s1_v_q  <= accept;
      pulse_q <= s1_v_q & match;
      if (s1_v_q && match && (count_q != '1)) begin
        count_q <= count_q + COUNT_W'(1);
      end
      if (s1_v_q && any_bad_q) begin
        bad_digit_q <= 1'b1;
      end
    end
  end

  assign match_pulse = pulse_q;
  assign match_count = count_q;
  assign bad_digit   = bad_digit_q;

endmodule

// File: tb/tb_pw_candidate_checker.sv
module tb_pw_candidate_checker;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;

  logic        match_pulse;
  logic [15:0] match_count;
  logic        bad_digit;
  logic        done;

  logic        match_pulse2;
  logic [1:0]  match_count2;
  logic        bad_digit2;
  logic        done2;

  pw_candidate_checker_if #(.DIGITS(6)) in_if  ();
  pw_candidate_checker_if #(.DIGITS(6)) in_if2 ();

  // Second instance (COUNT_W=2) sees identical stimulus; used for saturation.
  assign in_if2.in_valid  = in_if.in_valid;
  assign in_if2.in_digits = in_if.in_digits;
  assign in_if2.in_last   = in_if.in_last;

  pw_candidate_checker #(.DIGITS(6), .COUNT_W(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .in_if       (in_if.slave),
    .match_pulse (match_pulse),
    .match_count (match_count),
    .bad_digit   (bad_digit),
    .done        (done)
  );

  pw_candidate_checker #(.DIGITS(6), .COUNT_W(2)) dut2 (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .in_if       (in_if2.slave),
    .match_pulse (match_pulse2),
    .match_count (match_count2),
    .bad_digit   (bad_digit2),
    .done        (done2)
  );

  always #5 clk = ~clk;

  // ---------------- scoreboard / reference state ----------------
  typedef struct {
    logic m;
    logic b;
    int   due;
  } sb_t;

  typedef enum int {M_IDLE, M_RUN, M_DRAIN, M_DONE} mstate_e;

  sb_t         sb[$];
  mstate_e     ms;
  int          cyc;
  logic        e_pulse;
  logic [15:0] e_cnt;
  logic [1:0]  e_cnt2;
  logic        e_bad;

  int total;
  int n_bad;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
    end
  endtask

  // Left-to-right hex notation -> bus with the leftmost digit in [3:0].
  function automatic logic [23:0] cand(input logic [23:0] lr);
    logic [23:0] o;
    for (int i = 0; i < 6; i++) o[4*i +: 4] = lr[4*(5-i) +: 4];
    return o;
  endfunction

  // One clock: drive at negedge, advance reference model, check after edge.
  task automatic tick(input logic r, input logic s, input logic v,
                      input logic [23:0] lr, input logic l,
                      input logic m, input logic b);
    logic acc;
    logic s1_busy;
    rst             = r;
    start           = s;
    in_if.in_valid  = v;
    in_if.in_digits = cand(lr);
    in_if.in_last   = l;

    acc     = r && !s && v && (ms == M_RUN);
    s1_busy = (sb.size() > 0) && (sb[sb.size()-1].due == cyc + 1);
    if (!r) begin
      sb.delete();
      ms = M_IDLE; e_cnt = '0; e_cnt2 = '0; e_bad = 1'b0;
    end else if (s) begin
      sb.delete();
      ms = M_RUN; e_cnt = '0; e_cnt2 = '0; e_bad = 1'b0;
    end else begin
      if (acc) sb.push_back('{m: m, b: b, due: cyc + 2});
      case (ms)
        M_RUN:   if (acc && l) ms = M_DRAIN;
        M_DRAIN: if (!s1_busy) ms = M_DONE;
        default: ;
      endcase
    end

    @(posedge clk);
    cyc++;
    e_pulse = 1'b0;
    if (sb.size() > 0 && sb[0].due == cyc) begin
      sb_t e;
      e = sb.pop_front();
      e_pulse = e.m;
      if (e.m && e_cnt != 16'hFFFF) e_cnt++;
      if (e.m && e_cnt2 != 2'd3) e_cnt2++;
      if (e.b) e_bad = 1'b1;
    end

    @(negedge clk);
    check("match_pulse", 32'(match_pulse), 32'(e_pulse));
    check("match_count", 32'(match_count), 32'(e_cnt));
    check("match_count_w2", 32'(match_count2), 32'(e_cnt2));
    check("bad_digit", 32'(bad_digit), 32'(e_bad));
    check("done", 32'(done), 32'(ms == M_DONE));
    check("in_ready", 32'(in_if.in_ready), 32'(ms == M_RUN));
  endtask

  typedef struct {
    logic        r;
    logic        s;
    logic        v;
    logic [23:0] lr;
    logic        l;
    logic        m;
    logic        b;
  } vec_t;

  vec_t tbl[$];

  initial begin
    total = 0; n_bad = 0; cyc = 0;
    ms = M_IDLE; e_cnt = '0; e_cnt2 = '0; e_bad = 1'b0; e_pulse = 1'b0;
    rst = 1'b0; start = 1'b0;
    in_if.in_valid = 1'b0; in_if.in_digits = '0; in_if.in_last = 1'b0;

    //                 r     s     v     digits(L->R)  last  match bad
    // reset, then idle without start
    tbl.push_back('{1'b0, 1'b0, 1'b0, 24'h000000, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 1'b1, 1'b1, 24'h111111, 1'b1, 1'b0, 1'b0});
    tbl.push_back('{1'b1, 1'b0, 1'b1, 24'h111111, 1'b0, 1'b0, 1'b0});
    // single 111111 with last
    tbl.push_back('{1'b1, 1'b1, 1'b0, 24'h000000, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{1'b1, 1'b0, 1'b1, 24'h111111, 1'b1, 1'b1, 1'b0});
    tbl.push_back('{1'b1, 1'b0, 1'b0, 24'h000000, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{1'b1, 1'b0, 1'b0, 24'h000000, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{1'b1, 1'b0, 1'b1, 24'h111111, 1'b1, 1'b0, 1'b0});
    // back-to-back stream
    tbl.push_back('{1'b1, 1'b1, 1'b0, 24'h000000, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{1'b1, 1'b0, 1'b1, 24'h122345, 1'b0, 1'b1, 1'b0});
    tbl.push_back('{1'b1, 1'b0, 1'b1, 24'h111123, 1'b0, 1'b1, 1'b0});
    tbl.push_back('{1'b1, 1'b0, 1'b1, 24'h135679, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{1'b1, 1'b0, 1'b1, 24'h223450, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{1'b1, 1'b0, 1'b1, 24'h123789, 1'b1, 1'b0, 1'b0});
    tbl.push_back('{1'b1, 1'b0, 1'b0, 24'h000000, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{1'b1, 1'b0, 1'b0, 24'h000000, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{1'b1, 1'b0, 1'b0, 24'h000000, 1'b0, 1'b0, 1'b0});
    // bad digit, bubble carrying in_last (ignored), then valid match
    tbl.push_back('{1'b1, 1'b1, 1'b0, 24'h000000, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{1'b1, 1'b0, 1'b1, 24'h1A2233, 1'b0, 1'b0, 1'b1});
    tbl.push_back('{1'b1, 1'b0, 1'b0, 24'h111111, 1'b1, 1'b0, 1'b0});
    tbl.push_back('{1'b1, 1'b0, 1'b0, 24'h000000, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{1'b1, 1'b0, 1'b1, 24'h112233, 1'b1, 1'b1, 1'b0});
    tbl.push_back('{1'b1, 1'b0, 1'b0, 24'h000000, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{1'b1, 1'b0, 1'b0, 24'h000000, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{1'b1, 1'b0, 1'b0, 24'h000000, 1'b0, 1'b0, 1'b0});

    for (int i = 0; i < tbl.size(); i++) begin
      tick(tbl[i].r, tbl[i].s, tbl[i].v, tbl[i].lr, tbl[i].l, tbl[i].m, tbl[i].b);
    end

    // Saturation: five matches; the COUNT_W=2 instance must stop at 3.
    tick(1'b1, 1'b1, 1'b0, 24'h000000, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      tick(1'b1, 1'b0, 1'b1, 24'h111111, (i == 4), 1'b1, 1'b0);
    end
    for (int i = 0; i < 3; i++) tick(1'b1, 1'b0, 1'b0, 24'h000000, 1'b0, 1'b0, 1'b0);

    // start while matches are in flight: they are discarded; the candidate
    // presented with start is not taken.
    tick(1'b1, 1'b1, 1'b0, 24'h000000, 1'b0, 1'b0, 1'b0);
    tick(1'b1, 1'b0, 1'b1, 24'h111111, 1'b0, 1'b1, 1'b0);
    tick(1'b1, 1'b0, 1'b1, 24'h111111, 1'b0, 1'b1, 1'b0);
    tick(1'b1, 1'b1, 1'b1, 24'h111111, 1'b0, 1'b1, 1'b0);
    tick(1'b1, 1'b0, 1'b1, 24'h111111, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) tick(1'b1, 1'b0, 1'b0, 24'h000000, 1'b0, 1'b0, 1'b0);

    // Reset mid-RUN with in_valid high, then stays IDLE until start.
    tick(1'b1, 1'b1, 1'b0, 24'h000000, 1'b0, 1'b0, 1'b0);
    tick(1'b1, 1'b0, 1'b1, 24'h1F1111, 1'b0, 1'b0, 1'b1);
    tick(1'b1, 1'b0, 1'b1, 24'h111111, 1'b0, 1'b1, 1'b0);
    tick(1'b1, 1'b0, 1'b1, 24'h111111, 1'b0, 1'b1, 1'b0);
    tick(1'b0, 1'b0, 1'b1, 24'h111111, 1'b0, 1'b1, 1'b0);
    tick(1'b1, 1'b0, 1'b1, 24'h111111, 1'b1, 1'b1, 1'b0);
    tick(1'b1, 1'b0, 1'b1, 24'h111111, 1'b1, 1'b1, 1'b0);
    tick(1'b1, 1'b1, 1'b0, 24'h000000, 1'b0, 1'b0, 1'b0);
    tick(1'b1, 1'b0, 1'b1, 24'h455566, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) tick(1'b1, 1'b0, 1'b0, 24'h000000, 1'b0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, n_bad);
    $finish;
  end

endmodule
